// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: adds two WIDTH-bit operands one nibble per clock
// through a single shared four_bit_fulladder, LSB slice first, with the
// inter-slice carry held in a register. Valid/ready handshakes on both sides.
//
// Optional feature macro: NIBBLE_SERIAL_ADDER_CTRL_SUB_EN
//   When defined, adds a SUB input latched with the operands. SUB=1 computes
//   A-B by inverting each B slice and forcing the initial carry to 1
//   (C0 is ignored); Cout=1 then means no borrow.

// 4-bit ripple-carry adder shared by the sequencer.
module four_bit_fulladder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C0,
    output logic [3:0] S,
    output logic       C4
);

    logic [4:0] carry;

    // Ripple the carry through the four bit positions.
    always_comb begin
        carry    = '0;
        carry[0] = C0;
        S        = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            S[i]         = A[i] ^ B[i] ^ carry[i];
            carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
        C4 = carry[4];
    end

endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0,
`ifdef NIBBLE_SERIAL_ADDER_CTRL_SUB_EN
    input  logic             SUB,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);

    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_width_check
        $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state_q,     state_d;
    logic [IDXW-1:0]   idx_q,       idx_d;
    logic              carry_q,     carry_d;
    logic [WIDTH-1:0]  a_q,         a_d;
    logic [WIDTH-1:0]  b_q,         b_d;
    logic [WIDTH-1:0]  s_q,         s_d;
    logic              cout_q,      cout_d;
    logic              v_q,         v_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;
`ifdef NIBBLE_SERIAL_ADDER_CTRL_SUB_EN
    logic              sub_q,       sub_d;
`endif

    logic [3:0] add_a;
    logic [3:0] add_b;
    logic [3:0] add_s;
    logic       add_c4;

    // Select the operand nibbles for the current slice; B is inverted for subtract.
    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (idx_q == IDXW'(i)) begin
                add_a = a_q[4*i +: 4];
                add_b = b_q[4*i +: 4];
            end
        end
`ifdef NIBBLE_SERIAL_ADDER_CTRL_SUB_EN
        add_b = add_b ^ {4{sub_q}};
`endif
    end

    four_bit_fulladder u_adder (
        .A  (add_a),
        .B  (add_b),
        .C0 (carry_q),
        .S  (add_s),
        .C4 (add_c4)
    );

    // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        s_d         = s_q;
        cout_d      = cout_q;
        v_d         = v_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef NIBBLE_SERIAL_ADDER_CTRL_SUB_EN
        sub_d       = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d         = A;
                    b_d         = B;
                    carry_d     = C0;
                    idx_d       = '0;
                    s_d         = '0;
                    state_d     = RUN;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_CTRL_SUB_EN
                    sub_d       = SUB;
                    if (SUB) begin
                        carry_d = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < NSLICE; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        s_d[4*i +: 4] = add_s;
                    end
                end
                carry_d = add_c4;
                if (idx_q == LAST_IDX) begin
                    // add_b already carries the inversion, so V sees the effective B sign.
                    cout_d      = add_c4;
                    v_d         = (a_q[WIDTH-1] == add_b[3]) && (add_s[3] != a_q[WIDTH-1]);
                    idx_d       = '0;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; asynchronous reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            v_q         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_CTRL_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            cout_q      <= cout_d;
            v_q         <= v_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef NIBBLE_SERIAL_ADDER_CTRL_SUB_EN
            sub_q       <= sub_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign Cout      = cout_q;
    assign V         = v_q;

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that adds two WIDTH-bit operands by time-multiplexing a single instance of the team's 4-bit ripple-carry adder `four_bit_fulladder`.
- Processes one nibble slice per clock, LSB slice first, and carries C4 between slices in a register.
- Valid/ready handshakes on the input and output sides let it sit between a request source and a result consumer that share one narrow adder.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise).
- NSLICE, WIDTH/4, derived localparam: number of adder passes per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept an operation
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- C0  input  1  carry-in for the LSB slice
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- S  output  WIDTH  sum
- Cout  output  1  carry out of the MSB slice
- V  output  1  signed overflow

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, S=0, Cout=0, V=0, slice index=0, carry reg=0, operand regs=0.
- FSM states: IDLE, RUN, DONE.
- IDLE
  - in_ready=1.
  - On an edge with in_valid=1, latch A, B and C0; set carry reg=C0, index=0, S=0; go to RUN.
- RUN
  - in_ready=0, out_valid=0.
  - Each edge: adder input is A_reg[4*idx+:4], B_reg[4*idx+:4], carry reg.
  - Write the adder's S into S[4*idx+:4]; carry reg <= C4; idx++.
  - On the edge that processes idx=NSLICE-1: Cout <= C4; V <= (A_reg[MSB]==B_reg[MSB]) && (sum MSB != A_reg[MSB]); go to DONE.
- DONE
  - out_valid=1; S, Cout and V are held stable.
  - On an edge with out_ready=1, go to IDLE; out_valid drops after that edge.
- Latency: if the request is accepted at edge t0, out_valid is high after edge t0+NSLICE.
- Minimum issue interval is NSLICE+2 cycles. in_ready is high only in IDLE; there is no accept in DONE.
- Operands are captured at acceptance. A, B and C0 changes afterwards have no effect.
- in_valid during RUN or DONE is ignored, with no queueing.
- S is only meaningful while out_valid=1. Partial slices are visible in RUN and must not be consumed.
- Carry wrap: an all-ones sum plus carry propagates through every slice via the carry reg. Cout reports the final C4; the result is WIDTH bits modulo 2^WIDTH.
- out_ready held low: remain in DONE indefinitely with outputs stable.
- out_ready high before out_valid has no effect.
- Reset mid-operation (RUN or DONE): immediately return to reset values; the partial result is discarded.
- After reset release, the next accepted operation computes correctly.
- WIDTH=4 (NSLICE=1): RUN lasts exactly one cycle.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_CTRL_SUB_EN.
- Defined:
  - Adds input port SUB (1 bit), latched with the operands.
  - SUB=1: each B slice is inverted before the adder; the carry reg initialises to 1 and C0 is ignored; V uses the inverted B MSB.
  - Result is A-B mod 2^WIDTH; Cout=1 means no borrow.
  - SUB=0: behaves as an add.
- Undefined: SUB port absent; add only.

Test Plan:
- WIDTH=16, A=0x1234, B=0x0001, C0=0, accept at t0 -> out_valid after t0+4; S=0x1235, Cout=0, V=0.
- A=0xFFFF, B=0x0001, C0=0 -> S=0x0000, Cout=1, V=0 (carry through all 4 slices). Then A=0x0000, B=0x0000, C0=1 -> S=0x0001, Cout=0.
- A=0x7FFF, B=0x0001 -> S=0x8000, V=1, Cout=0; A=0x8000, B=0x8000 -> S=0x0000, Cout=1, V=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> S/Cout/V stable, in_ready=0, a new in_valid is ignored. Raise out_ready -> IDLE next edge; the next op is accepted one edge later.
- Drop rst_n during RUN after 2 slices -> out_valid=0, S=0, in_ready=1 asynchronously. Then 0x00F0+0x0010 -> S=0x0100.
- With NIBBLE_SERIAL_ADDER_CTRL_SUB_EN: A=0x0005, B=0x0007, SUB=1 -> S=0xFFFE, Cout=0. A=0x0007, B=0x0005, SUB=1 -> S=0x0002, Cout=1.
